axil_cmd_master: RTL
====================

Name: axil_cmd_master

Overview:
- Fabric-side AXI4-Lite initiator. Turns single read/write commands from a valid/ready command port into AXI4-Lite transactions.
- Returns the data and response on a valid/ready response port.
- Drives AXIL register slaves from PL logic (sequencers, self-test) without the PS. One outstanding transaction at a time.

Parameters:
- ADDRW, 7, AXI address width
- DATAW, 32, AXI data width (32 or 64); strobe width is DATAW/8
- TIMEOUT_CYC, 1024, handshake wait limit in clocks (only with AXIL_MASTER_TIMEOUT_EN)

Ports:
- clk100  in  1  clock
- rstn  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  ADDRW  byte address
- cmd_wdata  in  DATAW  write data
- cmd_wstrb  in  DATAW/8  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATAW  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP of the transaction
- rsp_timeout  out  1  transaction timed out
- M_AXI_AWADDR  out  ADDRW  write address
- M_AXI_AWVALID  out  1  write address valid
- M_AXI_AWREADY  in  1  write address ready
- M_AXI_WDATA  out  DATAW  write data
- M_AXI_WSTRB  out  DATAW/8  write strobes
- M_AXI_WVALID  out  1  write data valid
- M_AXI_WREADY  in  1  write data ready
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  write response valid
- M_AXI_BREADY  out  1  write response ready
- M_AXI_ARADDR  out  ADDRW  read address
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARREADY  in  1  read address ready
- M_AXI_RDATA  in  DATAW  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  read data ready
- M_AXI_AWPROT, M_AXI_ARPROT  out  3  constant 3'b000

Behaviour:
- Reset (rstn=0 at a clk100 edge): all valids and readies low, state IDLE, rsp_* = 0, address/data registers 0. Reset mid-transaction abandons the transaction immediately; the system resets the slave together with this block.
- States: IDLE, WR (AW+W), WB, RA, RD, RSP.
- IDLE: cmd_ready=1. On cmd_valid, register the command.
  - Write: next cycle AWVALID=WVALID=1, go to WR.
  - Read: next cycle ARVALID=1, go to RA.
- WR:
  - Each valid drops the cycle after its own ready is sampled high. AW and W are tracked by independent done flags, so either order or the same cycle is allowed.
  - When both are done: BREADY=1, go to WB.
- WB: on BVALID, capture BRESP, BREADY=0, rsp_rdata=0, go to RSP.
- RA: on ARREADY, ARVALID=0, RREADY=1, go to RD.
- RD: on RVALID, capture RDATA/RRESP, RREADY=0, go to RSP.
- RSP: rsp_valid=1, held stable until rsp_ready. On rsp_ready, return to IDLE with rsp_valid=0.
- Back-to-back commands are allowed; cmd_ready=0 in every state except IDLE.
- Address, data and strobe outputs hold stable while their valid is high (AXI rule). A valid, once raised, never drops before its ready.
- Minimum latency, slave ready always high:
  - Write: cmd accept to rsp_valid = 4 cycles.
  - Read: cmd accept to rsp_valid = 4 cycles.
- SLVERR/DECERR are passed through unchanged; they are not treated as errors internally.

Optional Feature:
- AXIL_MASTER_TIMEOUT_EN defined:
  - A counter clears on each state entry and counts every cycle spent in WR, WB, RA or RD.
  - When it reaches TIMEOUT_CYC: drop all M_AXI valids and readies, set rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, go to RSP.
- Undefined: no counter; rsp_timeout tied 0; the block waits indefinitely.

Decomposition:
- Package axil_pkg holds:
  - state enum typedef
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - default ADDRW/DATAW
- No sub-module; single FSM file. The timeout counter is inline under the macro.

Test Plan:
- Write 0x10 = 0xDEADBEEF, strb 4'hF, slave ready immediately -> one AW/W handshake; rsp_valid 4 cycles after accept; rsp_resp=0; rsp_rdata=0.
- Read 0x10 after that write, using the axil_reg32_2 model -> rsp_rdata=0xDEADBEEF, rsp_resp=0.
- Write with WREADY 5 cycles before AWREADY, then the reverse order -> each valid drops exactly one cycle after its own ready; exactly one B accepted.
- Slave returns RRESP=2'b10, and rsp_ready is held low 10 cycles -> rsp fields stable throughout; cmd_ready=0 until the response is consumed.
- rstn low while in RD -> next cycle all valids/readies 0, cmd_ready=1 after release.
- Macro on, TIMEOUT_CYC=16, ARREADY never asserted -> ARVALID drops after 16 cycles; rsp_timeout=1, rsp_resp=2'b10.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master.
//   - axil_state_e : FSM state encoding
//   - RESP_*       : AXI response codes
//   - AXIL_ADDRW / AXIL_DATAW : default bus widths
package axil_pkg;

  localparam int AXIL_ADDRW = 7;
  localparam int AXIL_DATAW = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,   // AW and W in flight
    ST_WB,   // waiting for B
    ST_RA,   // AR in flight
    ST_RD,   // waiting for R
    ST_RSP   // response held for the command side
  } axil_state_e;

endpackage

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-Lite initiator driven by a
// valid/ready command port, answering on a valid/ready response port.
//
// Ports
//   clk100, rstn            clock, synchronous active-low reset
//   cmd_*                   command in (wr, addr, wdata, wstrb)
//   rsp_*                   response out (rdata, resp, timeout)
//   M_AXI_*                 AXI4-Lite master interface
//
// Build option
//   AXIL_MASTER_TIMEOUT_EN  when defined, any wait in WR/WB/RA/RD longer
//                           than TIMEOUT_CYC cycles abandons the bus
//                           transaction and answers SLVERR with
//                           rsp_timeout=1. Otherwise the block waits forever.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int ADDRW       = AXIL_ADDRW,
  parameter int DATAW       = AXIL_DATAW,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk100,
  input  logic               rstn,
  // command port
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wr,
  input  logic [ADDRW-1:0]   cmd_addr,
  input  logic [DATAW-1:0]   cmd_wdata,
  input  logic [DATAW/8-1:0] cmd_wstrb,
  // response port
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATAW-1:0]   rsp_rdata,
  output logic [1:0]         rsp_resp,
  output logic               rsp_timeout,
  // AXI4-Lite master
  output logic [ADDRW-1:0]   M_AXI_AWADDR,
  output logic [2:0]         M_AXI_AWPROT,
  output logic               M_AXI_AWVALID,
  input  logic               M_AXI_AWREADY,
  output logic [DATAW-1:0]   M_AXI_WDATA,
  output logic [DATAW/8-1:0] M_AXI_WSTRB,
  output logic               M_AXI_WVALID,
  input  logic               M_AXI_WREADY,
  input  logic [1:0]         M_AXI_BRESP,
  input  logic               M_AXI_BVALID,
  output logic               M_AXI_BREADY,
  output logic [ADDRW-1:0]   M_AXI_ARADDR,
  output logic [2:0]         M_AXI_ARPROT,
  output logic               M_AXI_ARVALID,
  input  logic               M_AXI_ARREADY,
  input  logic [DATAW-1:0]   M_AXI_RDATA,
  input  logic [1:0]         M_AXI_RRESP,
  input  logic               M_AXI_RVALID,
  output logic               M_AXI_RREADY
);

  axil_state_e        state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               bready_q, bready_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic [ADDRW-1:0]   addr_q, addr_d;
  logic [DATAW-1:0]   wdata_q, wdata_d;
  logic [DATAW/8-1:0] wstrb_q, wstrb_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATAW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs;
  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q  & M_AXI_WREADY;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             waiting;
  assign waiting = (state_q == ST_WR) || (state_q == ST_WB) ||
                   (state_q == ST_RA) || (state_q == ST_RD);
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready is registered, so it is low for the first cycle after reset
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (cmd_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RA;
          end
        end
      end
      ST_WR: begin
        // AW and W complete independently; leave as soon as both are done,
        // counting a handshake happening on this very edge.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WB;
        end
      end
      ST_WB: begin
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RA: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD;
        end
      end
      ST_RD: begin
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    tmo_cnt_d     = '0;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q == ST_IDLE && cmd_valid && cmd_ready_q) rsp_timeout_d = 1'b0;
    if (waiting) begin
      // Fires on the edge where the count would reach TIMEOUT_CYC, so a
      // stuck valid is high for exactly TIMEOUT_CYC cycles.
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_timeout_d = 1'b1;
        rsp_resp_d    = RESP_SLVERR;
        rsp_rdata_d   = '0;
        rsp_valid_d   = 1'b1;
        state_d       = ST_RSP;
      end else if (state_d == state_q) begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk100) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge clk100) begin
    if (!rstn) begin
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TIMEOUT_CYC;
  assign rsp_timeout    = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
